// File: rtl/mul_column_acc.sv
// mul_column_acc: iterative column accumulator summing LANES operand-pair products over one shared multiplier.
// Define MULCOL_CIN_EN to add the cin port and seed the accumulator with it.
module mul_column_acc #(
    parameter int LANES = 2,
    parameter int OPW   = 8,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*OPW-1:0] a_in,
    input  logic [LANES*OPW-1:0] b_in,
`ifdef MULCOL_CIN_EN
    input  logic [2*OPW-1:0]     cin,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*OPW-1:0]     sum_out,
    output logic [CW-1:0]        carry_out,
    output logic                 busy
);
    localparam int AW = 2*OPW + CW;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [AW-1:0]          res_q, res_d;
    logic [LANES*OPW-1:0]   a_q, a_d, b_q, b_d;
    logic [OPW-1:0]         a_sel, b_sel;
    logic [2*OPW-1:0]       prod;
    logic [AW-1:0]          acc_sum, seed;
    logic                   accept;

    assign a_sel    = a_q[idx_q*OPW +: OPW];
    assign b_sel    = b_q[idx_q*OPW +: OPW];
    assign prod     = {{OPW{1'b0}}, a_sel} * {{OPW{1'b0}}, b_sel};
    assign acc_sum  = acc_q + {{CW{1'b0}}, prod};
`ifdef MULCOL_CIN_EN
    assign seed     = {{CW{1'b0}}, cin};
`else
    assign seed     = '0;
`endif
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MAC);
    assign sum_out   = res_q[2*OPW-1:0];
    assign carry_out = res_q[AW-1:2*OPW];

    // Next state: one lane per MAC cycle; result captured separately so it survives the next accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: state_d = in_valid ? MAC : IDLE;
            MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(LANES-1)) begin
                    state_d = DONE;
                    res_d   = acc_sum;
                end
            end
            DONE: state_d = out_ready ? (in_valid ? MAC : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = seed;
            idx_d = '0;
        end
    end

    // State and datapath registers; reset drops any set in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
endmodule
